// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM states, default widths and
// the response bundle handed back to the command side.
package apb_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;
  localparam int MAX_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master.sv
// APB requester: valid/ready command in, APB transfer out, one-cycle
// response pulse back, with wait-state timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PAddr,
  output logic              PWrite,
  output logic              PSel,
  output logic              PEnable,
  output logic [DATA_W-1:0] PWData,
  input  logic [DATA_W-1:0] PRData,
  input  logic              PReady,
  input  logic              PSlvErr
);

  localparam int CW =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] CMAX = '1;

  apb_state_e        state_q, state_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  apb_rsp_t          rsp_q, rsp_d;
  logic              vld_q, vld_d;
  logic              rdy_q, rdy_d;
  logic              load;
  logic              tmo_hit;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              pwrite_q;

  // Abort once the wait count would reach the limit on this edge.
  always_comb begin
    tmo_hit = 1'b0;
    if (TIMEOUT_CYC != 0)
      tmo_hit = (int'(wcnt_q) + 1) >= TIMEOUT_CYC;
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rsp_d   = '0;
    vld_d   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && rdy_q) begin
          load    = 1'b1;
          wcnt_d  = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PReady) begin
          state_d   = IDLE;
          vld_d     = 1'b1;
          rsp_d.err = PSlvErr;
          if (!pwrite_q)
            rsp_d.rdata[DATA_W-1:0] = PRData;
        end else begin
          if (wcnt_q != CMAX)
            wcnt_d = wcnt_q + 1'b1;
          if (tmo_hit) begin
            state_d       = IDLE;
            vld_d         = 1'b1;
            rsp_d.err     = 1'b1;
            rsp_d.timeout = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      rsp_q    <= '0;
      vld_q    <= 1'b0;
      rdy_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rsp_q   <= rsp_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      if (load) begin
        paddr_q  <= cmd_addr;
        pwdata_q <= cmd_wdata;
        pwrite_q <= cmd_write;
      end
    end
  end

  assign cmd_ready   = rdy_q;
  assign rsp_valid   = vld_q;
  assign rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign PAddr       = paddr_q;
  assign PWData      = pwdata_q;
  assign PWrite      = pwrite_q;
  assign PSel        = (state_q != IDLE);
  assign PEnable     = (state_q == ACCESS);

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: APB slave model with programmable wait states
// and errors, vector table, corner sequences and randomized traffic.
module tb_apb_master;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] PAddr;
  logic          PWrite;
  logic          PSel;
  logic          PEnable;
  logic [DW-1:0] PWData;
  logic [DW-1:0] PRData = '0;
  logic          PReady = 1'b0;
  logic          PSlvErr = 1'b0;

  apb_master #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PAddr(PAddr), .PWrite(PWrite), .PSel(PSel),
    .PEnable(PEnable), .PWData(PWData),
    .PRData(PRData), .PReady(PReady), .PSlvErr(PSlvErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  typedef struct {
    logic        w;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          acc;
    int          due;
  } exp_t;

  typedef struct {
    int   waits;
    logic err;
  } scfg_t;

  exp_t  expq[$];
  scfg_t sq[$];
  exp_t  f;

  logic [AW-1:0] exp_paddr  = '0;
  logic [DW-1:0] exp_pwdata = '0;
  logic          exp_pwrite = 1'b0;

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {16'hA5A5, a};
  endfunction

  // Slave model: a memory that answers after a per-transfer wait count.
  logic [31:0] smem [logic [15:0]];
  scfg_t cur;
  bit    active = 1'b0;
  int    acc_n = 0;

  always @(negedge clk) begin
    if (PSel && PEnable) begin
      if (!active) begin
        active = 1'b1;
        acc_n  = 0;
        if (sq.size() > 0) cur = sq.pop_front();
        else cur = '{0, 1'b0};
      end
      if (acc_n >= cur.waits) begin
        PReady  = 1'b1;
        PSlvErr = cur.err;
        PRData  = smem.exists(PAddr) ? smem[PAddr] : dflt(PAddr);
        if (PWrite && !cur.err) smem[PAddr] = PWData;
      end else begin
        PReady  = 1'b0;
        PSlvErr = 1'($urandom);
        PRData  = $urandom;
      end
      acc_n++;
    end else begin
      active  = 1'b0;
      PReady  = 1'($urandom);
      PSlvErr = 1'($urandom);
      PRData  = $urandom;
    end
  end

  // Cycle-by-cycle monitor against the expected transfer queue.
  always @(negedge clk) begin
    logic esel, een, erdy;
    if (chk_en) begin
      esel = 1'b0;
      een  = 1'b0;
      erdy = 1'b1;
      if (expq.size() > 0) begin
        f = expq[0];
        if (cyc == f.acc) esel = 1'b1;
        else if (cyc > f.acc && cyc < f.due) begin
          esel = 1'b1;
          een  = 1'b1;
        end
        erdy = (cyc >= f.due);
      end
      chk1("PSel", PSel, esel);
      chk1("PEnable", PEnable, een);
      chk1("cmd_ready", cmd_ready, erdy);
      chk("PAddr", {16'd0, PAddr}, {16'd0, exp_paddr});
      chk("PWData", PWData, exp_pwdata);
      chk1("PWrite", PWrite, exp_pwrite);
      if (rsp_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_spurious: got rsp_valid=1 expected 0 cycle %0d",
                   cyc);
        end else begin
          f = expq.pop_front();
          chk("rsp_latency", cyc, f.due);
          chk("rsp_rdata", rsp_rdata, f.rdata);
          chk1("rsp_err", rsp_err, f.err);
          chk1("rsp_timeout", rsp_timeout, f.to);
        end
      end else begin
        chk("rsp_idle", {29'd0, rsp_err, rsp_timeout, |rsp_rdata}, 32'd0);
        if (expq.size() > 0 && cyc >= expq[0].due) begin
          f = expq.pop_front();
          chk("rsp_missing", cyc, f.due - 1);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [15:0] a,
                       input logic [31:0] d, input int waits,
                       input logic serr, input logic [31:0] xr,
                       input logic xe, input logic xt,
                       input int xlat, output int acc);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk1("accept_wait", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    sq.push_back('{waits, serr});
    @(posedge clk);
    expq.push_back('{w, xr, xe, xt, acc, acc + xlat});
    exp_paddr  = a;
    exp_pwdata = d;
    exp_pwrite = w;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 16'($urandom);
    cmd_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() > 0) begin
      chk("drain", expq.size(), 0);
      expq.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    chk1({tag, "_PSel"}, PSel, 1'b0);
    chk1({tag, "_PEnable"}, PEnable, 1'b0);
    chk({tag, "_PAddr"}, {16'd0, PAddr}, 32'd0);
    chk({tag, "_PWData"}, PWData, 32'd0);
    chk1({tag, "_PWrite"}, PWrite, 1'b0);
    chk1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk1({tag, "_rsp_err"}, rsp_err, 1'b0);
    chk1({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
  endtask

  // Reference model for random traffic, from the transfer rules.
  logic [31:0] ref_mem [logic [15:0]];

  task automatic rand_cmd();
    logic        w, serr, xe, xt;
    logic [15:0] a;
    logic [31:0] d, xr;
    int          waits, lat, acc;
    w     = 1'($urandom_range(0, 1));
    a     = 16'h100 + 16'(4 * $urandom_range(0, 7));
    d     = $urandom;
    waits = $urandom_range(0, 5);
    serr  = ($urandom_range(0, 4) == 0);
    if (waits >= TMO) begin
      xr = '0; xe = 1'b1; xt = 1'b1;
      lat = 1 + TMO;
    end else begin
      xe  = serr;
      xt  = 1'b0;
      lat = 2 + waits;
      xr  = w ? 32'd0 : (ref_mem.exists(a) ? ref_mem[a] : dflt(a));
      if (w && !serr) ref_mem[a] = d;
    end
    issue(w, a, d, waits, serr, xr, xe, xt, lat, acc);
  endtask

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
    int          waits;
    logic        serr;
    logic [31:0] xr;
    logic        xe;
    logic        xt;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int acc1, acc2;
    tbl[0] = '{1'b1, 16'h50, 32'h50, 0, 1'b0, 32'h0, 1'b0, 1'b0, 2};
    tbl[1] = '{1'b0, 16'h50, 32'h0, 3, 1'b0, 32'h50, 1'b0, 1'b0, 5};
    tbl[2] = '{1'b1, 16'h50, 32'hDEADBEEF, 1, 1'b0, 32'h0, 1'b0, 1'b0, 3};
    tbl[3] = '{1'b0, 16'h50, 32'h0, 3, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 5};
    tbl[4] = '{1'b1, 16'h10, 32'h1234, 0, 1'b1, 32'h0, 1'b1, 1'b0, 2};
    tbl[5] = '{1'b0, 16'h10, 32'h0, 0, 1'b0, 32'hA5A50010, 1'b0, 1'b0, 2};
    tbl[6] = '{1'b0, 16'h30, 32'h0, 99, 1'b0, 32'h0, 1'b1, 1'b1, 5};
    tbl[7] = '{1'b1, 16'h30, 32'h77, 99, 1'b0, 32'h0, 1'b1, 1'b1, 5};
    tbl[8] = '{1'b0, 16'h30, 32'h0, 2, 1'b0, 32'hA5A50030, 1'b0, 1'b0, 4};
    tbl[9] = '{1'b0, 16'h40, 32'h0, 2, 1'b1, 32'hA5A50040, 1'b1, 1'b0, 4};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk1("ready_after_reset", cmd_ready, 1'b1);
    chk_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].waits, tbl[i].serr,
            tbl[i].xr, tbl[i].xe, tbl[i].xt, tbl[i].lat, acc1);
      wait_idle();
      if (i == 0) chk("slave_mem_50", smem[16'h50], 32'h50);
    end

    issue(1'b1, 16'h20, 32'hCAFE0020, 0, 1'b0, 32'h0, 1'b0, 1'b0, 2, acc1);
    issue(1'b0, 16'h20, 32'h0, 0, 1'b0, 32'hCAFE0020, 1'b0, 1'b0, 2, acc2);
    chk("b2b_spacing", acc2 - acc1, 3);
    wait_idle();

    issue(1'b0, 16'h60, 32'h0, 10, 1'b0, 32'h0, 1'b1, 1'b1, 5, acc1);
    repeat (2) @(negedge clk);
    chk1("mid_wait_PEnable", PEnable, 1'b1);
    chk_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midrst");
    expq.delete();
    exp_paddr  = '0;
    exp_pwdata = '0;
    exp_pwrite = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    issue(1'b1, 16'h60, 32'h600D0060, 1, 1'b0, 32'h0, 1'b0, 1'b0, 3, acc1);
    wait_idle();
    chk("slave_mem_60", smem[16'h60], 32'h600D0060);

    for (int i = 0; i < 40; i++) begin
      rand_cmd();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Parametrised APB requester. Converts a valid/ready command interface into APB read and write transfers, and returns a one-cycle response pulse.
- Supports PReady wait states, PSlvErr error reporting and a configurable wait-state timeout.
- Replaces ad-hoc bench tasks that drive APB pins. Sits between test or firmware-model stimulus and the APB slave/memory under test.

Parameters:
- ADDR_W, 16, APB address width.
- DATA_W, 32, APB data width (8, 16 or 32).
- TIMEOUT_CYC, 16, max ACCESS cycles with PReady=0 before abort. 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic samples on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSlvErr sampled at completion, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PAddr  out  ADDR_W  APB address.
- PWrite  out  1  APB direction.
- PSel  out  1  APB select.
- PEnable  out  1  APB enable.
- PWData  out  DATA_W  APB write data.
- PRData  in  DATA_W  APB read data.
- PReady  in  1  slave ready.
- PSlvErr  in  1  slave error.

Behaviour:
- Reset (synchronous, active-high): on the first posedge with rst=1, all outputs go to 0 (cmd_ready=0, PSel=0, PEnable=0, PAddr=0, PWData=0, PWrite=0, rsp_*=0), state=IDLE, wait counter=0.
- Reset mid-transfer: PSel/PEnable drop at that edge, the transfer is discarded, and no rsp_valid is issued.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid: register cmd_addr/cmd_wdata/cmd_write onto PAddr/PWData/PWrite; next state SETUP.
  - SETUP: PSel=1, PEnable=0, cmd_ready=0. Unconditionally next state ACCESS.
  - ACCESS: PSel=1, PEnable=1. PAddr/PWData/PWrite held stable.
    - PReady=1: transfer completes; capture PRData (reads) and PSlvErr; next state IDLE.
    - PReady=0: wait counter increments. If TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC, abort: next state IDLE, rsp_err=1, rsp_timeout=1.
- Response timing: rsp_valid is high for exactly the cycle after completion or abort (first IDLE cycle). rsp_* are 0 when rsp_valid=0.
- Latency, zero wait states: accept at edge N; SETUP in cycle N+1; ACCESS in cycle N+2; rsp_valid in cycle N+3. Each wait state adds 1 cycle.
- Minimum command spacing: 3 cycles. cmd_ready rises in the same cycle as rsp_valid, so a new command can be accepted at that edge (back-to-back).
- In IDLE, PAddr/PWData/PWrite retain their last values (no toggling) until the next accept.
- PSlvErr and PRData are ignored unless PSel && PEnable && PReady.
- A timeout on a read returns rsp_rdata=0.
- Wait counter: width $clog2(TIMEOUT_CYC+1) (min 1). Cleared on entering SETUP. Saturates; never wraps.
- cmd_valid while cmd_ready=0 is ignored; the command must be held by the requester.

Decomposition:
- Package apb_pkg holds:
  - typedef enum logic [1:0] apb_state_e {IDLE, SETUP, ACCESS};
  - localparam for the default widths;
  - typedef struct apb_rsp_t {rdata, err, timeout}.
- No sub-module: the FSM, capture registers and wait counter fit in a single module.

Test Plan:
- Write, zero wait: cmd write addr 16'h50, data 32'h50 -> PSel rises N+1, PEnable N+2, PAddr=16'h50 and PWData=32'h50 stable throughout, rsp_valid at N+3 with err=0; slave memory[16'h50]=32'h50.
- Read with 3 wait states: read 16'h50, PReady low 3 cycles, PRData=32'hDEADBEEF -> rsp_valid at N+6, rsp_rdata=32'hDEADBEEF, err=0.
- Slave error: write 16'h10 with PSlvErr=1 at completion -> rsp_err=1, rsp_timeout=0, rsp_valid one cycle only.
- Timeout: TIMEOUT_CYC=4, PReady held 0 -> abort after 4 ACCESS cycles, PSel=0 next cycle, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Back-to-back: cmd_valid held with two commands (write 16'h20, then read 16'h20) -> second accept on the rsp_valid cycle, read returns the written data, 3-cycle spacing.
- Reset mid-ACCESS: rst=1 during a wait state -> all outputs 0 at that edge, no rsp_valid, next command completes normally.
